// File: rtl/id_ex_operand_stage_pkg.sv
// Shared constants and types for the ID/EX operand stage: RV32I major opcodes,
// ALU control codes and the operand / forwarding select encodings.
package id_ex_operand_stage_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // ALU codes are {funct7[5], funct3} for the register-register ops
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_LUI  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef enum logic [1:0] {FWD_REG, FWD_MEM, FWD_WB} fwd_sel_e;
  typedef enum logic [1:0] {SRC1_RS1, SRC1_PC, SRC1_ZERO} src1_sel_e;
  typedef enum logic [1:0] {SRC2_RS2, SRC2_IMM, SRC2_FOUR} src2_sel_e;

  // Branch compare code: equality tests use SUB, signed/unsigned compares use SLT/SLTU
  function automatic logic [3:0] branch_alu_ctrl(input logic [2:0] funct3);
    logic [3:0] ctrl;
    ctrl = ALU_SUB;
    if (funct3[2]) begin
      ctrl = funct3[1] ? ALU_SLTU : ALU_SLT;
    end
    return ctrl;
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_alu_ctrl_decode.sv
// Combinational decode of opcode/funct fields into ALU control, operand
// selects, register usage and write-back attributes.
module alu_ctrl_decode
  import id_ex_operand_stage_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_ctrl,
  output src1_sel_e  src1_sel,
  output src2_sel_e  src2_sel,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       wen,
  output logic       is_load,
  output logic       legal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    src1_sel = SRC1_RS1;
    src2_sel = SRC2_RS2;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    wen      = 1'b0;
    is_load  = 1'b0;
    legal    = 1'b1;
    unique case (opcode)
      OPC_OP: begin
        alu_ctrl = {funct7_5, funct3};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        wen      = 1'b1;
      end
      // Only the shift-right group uses funct7[5] as an opcode bit for immediates
      OPC_OP_IMM: begin
        alu_ctrl = {(funct3 == 3'b101) ? funct7_5 : 1'b0, funct3};
        src2_sel = SRC2_IMM;
        uses_rs1 = 1'b1;
        wen      = 1'b1;
      end
      OPC_LOAD: begin
        src2_sel = SRC2_IMM;
        uses_rs1 = 1'b1;
        wen      = 1'b1;
        is_load  = 1'b1;
      end
      OPC_STORE: begin
        src2_sel = SRC2_IMM;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_LUI: begin
        alu_ctrl = ALU_LUI;
        src1_sel = SRC1_ZERO;
        src2_sel = SRC2_IMM;
        wen      = 1'b1;
      end
      OPC_AUIPC: begin
        src1_sel = SRC1_PC;
        src2_sel = SRC2_IMM;
        wen      = 1'b1;
      end
      OPC_JAL: begin
        src1_sel = SRC1_PC;
        src2_sel = SRC2_FOUR;
        wen      = 1'b1;
      end
      // The link value is pc+4, but the jump target still needs rs1
      OPC_JALR: begin
        src1_sel = SRC1_PC;
        src2_sel = SRC2_FOUR;
        uses_rs1 = 1'b1;
        wen      = 1'b1;
      end
      OPC_BRANCH: begin
        alu_ctrl = branch_alu_ctrl(funct3);
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded fields, resolves
// load-use hazards, and forwards EX/MEM and MEM/WB results into the operands.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_in,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [6:0]        id_opcode,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7_5,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_wen,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_wen,
  input  logic [XLEN-1:0]   wb_data,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [3:0]        alu_ctrl,
  output logic [XLEN-1:0]   src1,
  output logic [XLEN-1:0]   src2,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_wen,
  output logic              ex_is_load
);

  logic [3:0] dec_alu_ctrl;
  src1_sel_e  dec_src1_sel;
  src2_sel_e  dec_src2_sel;
  logic       dec_uses_rs1;
  logic       dec_uses_rs2;
  logic       dec_wen;
  logic       dec_is_load;
  logic       dec_legal;

  alu_ctrl_decode u_decode (
    .opcode   (id_opcode),
    .funct3   (id_funct3),
    .funct7_5 (id_funct7_5),
    .alu_ctrl (dec_alu_ctrl),
    .src1_sel (dec_src1_sel),
    .src2_sel (dec_src2_sel),
    .uses_rs1 (dec_uses_rs1),
    .uses_rs2 (dec_uses_rs2),
    .wen      (dec_wen),
    .is_load  (dec_is_load),
    .legal    (dec_legal)
  );

  logic              valid_q,    valid_d;
  logic [XLEN-1:0]   pc_q,       pc_d;
  logic [3:0]        ctrl_q,     ctrl_d;
  src1_sel_e         src1_sel_q, src1_sel_d;
  src2_sel_e         src2_sel_q, src2_sel_d;
  logic [REG_AW-1:0] rs1_q,      rs1_d;
  logic [REG_AW-1:0] rs2_q,      rs2_d;
  logic [XLEN-1:0]   rs1_val_q,  rs1_val_d;
  logic [XLEN-1:0]   rs2_val_q,  rs2_val_d;
  logic [XLEN-1:0]   imm_q,      imm_d;
  logic [REG_AW-1:0] rd_q,       rd_d;
  logic              wen_q,      wen_d;
  logic              is_load_q,  is_load_d;

  // A load in EX whose result is needed by the instruction in ID cannot be
  // forwarded in time; a flush makes the ID instruction irrelevant anyway.
  always_comb begin
    hazard_stall = 1'b0;
    if (!flush && valid_q && is_load_q && (rd_q != '0) && id_valid) begin
      hazard_stall = (dec_uses_rs1 && (id_rs1 == rd_q)) ||
                     (dec_uses_rs2 && (id_rs2 == rd_q));
    end
  end

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    ctrl_d     = ctrl_q;
    src1_sel_d = src1_sel_q;
    src2_sel_d = src2_sel_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rs1_val_d  = rs1_val_q;
    rs2_val_d  = rs2_val_q;
    imm_d      = imm_q;
    rd_d       = rd_q;
    wen_d      = wen_q;
    is_load_d  = is_load_q;
    if (stall_in) begin
      valid_d = valid_q;
    end else if (flush || hazard_stall || !dec_legal) begin
      valid_d    = 1'b0;
      pc_d       = '0;
      ctrl_d     = ALU_ADD;
      src1_sel_d = SRC1_RS1;
      src2_sel_d = SRC2_RS2;
      rs1_d      = '0;
      rs2_d      = '0;
      rs1_val_d  = '0;
      rs2_val_d  = '0;
      imm_d      = '0;
      rd_d       = '0;
      wen_d      = 1'b0;
      is_load_d  = 1'b0;
    end else begin
      valid_d    = id_valid;
      pc_d       = id_pc;
      ctrl_d     = dec_alu_ctrl;
      src1_sel_d = dec_src1_sel;
      src2_sel_d = dec_src2_sel;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      imm_d      = id_imm;
      rd_d       = id_rd;
      wen_d      = dec_wen && id_valid;
      is_load_d  = dec_is_load && id_valid;
      // The register file is written on this same edge, so its read data is stale
      rs1_val_d  = (wb_wen && (wb_rd != '0) && (wb_rd == id_rs1)) ? wb_data : id_rs1_data;
      rs2_val_d  = (wb_wen && (wb_rd != '0) && (wb_rd == id_rs2)) ? wb_data : id_rs2_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      ctrl_q     <= ALU_ADD;
      src1_sel_q <= SRC1_RS1;
      src2_sel_q <= SRC2_RS2;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_val_q  <= '0;
      rs2_val_q  <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
      wen_q      <= 1'b0;
      is_load_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      ctrl_q     <= ctrl_d;
      src1_sel_q <= src1_sel_d;
      src2_sel_q <= src2_sel_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rs1_val_q  <= rs1_val_d;
      rs2_val_q  <= rs2_val_d;
      imm_q      <= imm_d;
      rd_q       <= rd_d;
      wen_q      <= wen_d;
      is_load_q  <= is_load_d;
    end
  end

  function automatic fwd_sel_e fwd_pick(
    input logic [REG_AW-1:0] rs,
    input logic              m_wen,
    input logic [REG_AW-1:0] m_rd,
    input logic              w_wen,
    input logic [REG_AW-1:0] w_rd
  );
    fwd_sel_e sel;
    sel = FWD_REG;
    if (m_wen && (m_rd != '0) && (m_rd == rs)) begin
      sel = FWD_MEM;
    end else if (w_wen && (w_rd != '0) && (w_rd == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  fwd_sel_e        fwd1_sel;
  fwd_sel_e        fwd2_sel;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  // The younger EX/MEM result takes precedence over MEM/WB for the same register
  always_comb begin
    fwd1_sel = fwd_pick(rs1_q, mem_wen, mem_rd, wb_wen, wb_rd);
    fwd2_sel = fwd_pick(rs2_q, mem_wen, mem_rd, wb_wen, wb_rd);
    unique case (fwd1_sel)
      FWD_MEM: rs1_fwd = mem_result;
      FWD_WB:  rs1_fwd = wb_data;
      default: rs1_fwd = rs1_val_q;
    endcase
    unique case (fwd2_sel)
      FWD_MEM: rs2_fwd = mem_result;
      FWD_WB:  rs2_fwd = wb_data;
      default: rs2_fwd = rs2_val_q;
    endcase
  end

  always_comb begin
    unique case (src1_sel_q)
      SRC1_PC:   src1 = pc_q;
      SRC1_ZERO: src1 = '0;
      default:   src1 = rs1_fwd;
    endcase
    unique case (src2_sel_q)
      SRC2_IMM:  src2 = imm_q;
      SRC2_FOUR: src2 = XLEN'(32'd4);
      default:   src2 = rs2_fwd;
    endcase
  end

  assign ex_store_data = rs2_fwd;
  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign alu_ctrl      = ctrl_q;
  assign ex_rd         = rd_q;
  assign ex_wen        = wen_q;
  assign ex_is_load    = is_load_q;

endmodule
